// File: rtl/if_fetch_stage_pkg.sv
// Instruction fetch: shared constants and state encoding.
// Imported by the fetch stage and its bench.
package if_fetch_stage_pkg;

  localparam logic [31:0] FETCH_NOP      = 32'h0000_0013;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ISSUE,
    WAIT,
    HOLD,
    DRAIN
  } fetch_state_e;

  function automatic logic [31:0] pc_add4(input logic [31:0] p);
    return p + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bundle.
// Single outstanding request, response at most once.
interface if_fetch_stage_if;

  logic        req;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/if_fetch_stage.sv
// IF stage: owns the PC, issues imem requests,
// presents pc/pcAdd4/inst to IF/ID with bubbles.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter logic [31:0] NOP_INST = FETCH_NOP
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  if_fetch_stage_if.master         imem,
  output logic [31:0]              pc,
  output logic [31:0]              pcAdd4,
  output logic [31:0]              inst,
  output logic                     instValid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pcr_q, pcr_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc4_q, pc4_d;
  logic [31:0]  inst_q, inst_d;
  logic         iv_q, iv_d;
  logic         req_q, req_d;
  logic [31:0]  addr_q, addr_d;
  logic         skv_q, skv_d;
  logic [31:0]  skpc_q, skpc_d;
  logic [31:0]  skinst_q, skinst_d;

  // Next-state: redirect beats rvalid, rvalid beats stall.
  always_comb begin
    state_d  = state_q;
    pcr_d    = pcr_q;
    pc_d     = pc_q;
    pc4_d    = pc4_q;
    inst_d   = inst_q;
    iv_d     = iv_q;
    skv_d    = skv_q;
    skpc_d   = skpc_q;
    skinst_d = skinst_q;
    if (!stall) begin
      inst_d = NOP_INST;
      iv_d   = 1'b0;
    end
    if (redirect) begin
      pcr_d  = redirect_pc & ~32'h3;
      inst_d = NOP_INST;
      iv_d   = 1'b0;
      skv_d  = 1'b0;
      unique case (state_q)
        ISSUE:       state_d = req_q ? DRAIN : ISSUE;
        WAIT, DRAIN: state_d = imem.rvalid ? ISSUE : DRAIN;
        default:     state_d = ISSUE;
      endcase
    end else begin
      unique case (state_q)
        ISSUE: begin
          if (req_q) state_d = WAIT;
        end
        WAIT: begin
          if (imem.rvalid) begin
            pcr_d = pc_add4(pcr_q);
            if (stall) begin
              skv_d    = 1'b1;
              skpc_d   = pcr_q;
              skinst_d = imem.rdata;
              state_d  = HOLD;
            end else begin
              pc_d    = pcr_q;
              pc4_d   = pc_add4(pcr_q);
              inst_d  = imem.rdata;
              iv_d    = 1'b1;
              state_d = ISSUE;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            if (skv_q) begin
              pc_d   = skpc_q;
              pc4_d  = pc_add4(skpc_q);
              inst_d = skinst_q;
              iv_d   = 1'b1;
            end
            skv_d   = 1'b0;
            state_d = ISSUE;
          end
        end
        default: begin
          if (imem.rvalid) state_d = ISSUE;
        end
      endcase
    end
    // The cycle right after reset sits in ISSUE with no
    // pulse yet; it raises the pulse and stays in ISSUE.
    req_d  = (state_d == ISSUE);
    addr_d = pcr_d;
  end

  // All state and outputs registered; sync active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ISSUE;
      pcr_q    <= RESET_PC;
      pc_q     <= '0;
      pc4_q    <= '0;
      inst_q   <= NOP_INST;
      iv_q     <= 1'b0;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      skv_q    <= 1'b0;
      skpc_q   <= '0;
      skinst_q <= NOP_INST;
    end else begin
      state_q  <= state_d;
      pcr_q    <= pcr_d;
      pc_q     <= pc_d;
      pc4_q    <= pc4_d;
      inst_q   <= inst_d;
      iv_q     <= iv_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      skv_q    <= skv_d;
      skpc_q   <= skpc_d;
      skinst_q <= skinst_d;
    end
  end

  assign imem.req  = req_q;
  assign imem.addr = addr_q;
  assign pc        = pc_q;
  assign pcAdd4    = pc4_q;
  assign inst      = inst_q;
  assign instValid = iv_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: memory model plus
// pc/address scoreboards fed by the stimulus.
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] pc, pcAdd4, inst;
  logic        instValid;

  if_fetch_stage_if imem();

  if_fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(32'h0000_0013)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem),
    .pc          (pc),
    .pcAdd4      (pcAdd4),
    .inst        (inst),
    .instValid   (instValid)
  );

  always #5 clk = ~clk;

  int          nvec = 0;
  int          nbad = 0;
  logic [31:0] exp_pc[$];
  logic [31:0] exp_addr[$];
  int          lat = 1;
  int          cnt = 0;
  logic [31:0] paddr = '0;
  bit          got_new = 1'b0;

  function automatic logic [31:0] memw(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return (a << 7) | 32'h13;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One cycle: monitor outputs, then drive the memory side.
  task automatic step();
    logic [31:0] e;
    @(negedge clk);
    got_new = reset && !stall && instValid;
    if (got_new) begin
      if (exp_pc.size() == 0) begin
        chk("pc_unexp", exp_pc.size(), 1);
      end else begin
        e = exp_pc.pop_front();
        chk("pc", pc, e);
        chk("pcAdd4", pcAdd4, e + 32'd4);
        chk("inst", inst, memw(e));
      end
    end
    imem.rvalid = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        imem.rvalid = 1'b1;
        imem.rdata  = memw(paddr);
      end
    end
    if (imem.req === 1'b1) begin
      chk("overlap", cnt, 0);
      if (exp_addr.size() == 0)
        chk("addr_unexp", exp_addr.size(), 1);
      else
        chk("imem_addr", imem.addr, exp_addr.pop_front());
      cnt   = lat;
      paddr = imem.addr;
    end
  endtask

  task automatic run_until_new(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      seen = got_new;
    end
    if (!seen) chk("timeout", seen, 1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_pc4"}, pcAdd4, 32'h0);
    chk({tag, "_inst"}, inst, FETCH_NOP);
    chk({tag, "_v"}, instValid, 0);
    chk({tag, "_req"}, imem.req, 0);
  endtask

  initial begin
    imem.rvalid = 1'b0;
    imem.rdata  = '0;

    // reset state, then first two fetches
    repeat (3) step();
    chk_reset("rst");
    exp_addr.push_back(32'h0);
    exp_addr.push_back(32'h4);
    exp_addr.push_back(32'h8);
    exp_pc.push_back(32'h0);
    exp_pc.push_back(32'h4);
    reset = 1'b1;
    run_until_new(8);
    step();
    chk("bub_v", instValid, 0);
    chk("bub_inst", inst, FETCH_NOP);
    chk("bub_pc", pc, 32'h0);
    run_until_new(8);

    // stall across the response for addr 8
    exp_pc.push_back(32'h8);
    exp_addr.push_back(32'hC);
    stall = 1'b1;
    repeat (3) begin
      step();
      chk("frz_pc", pc, 32'h4);
      chk("frz_v", instValid, 1);
      chk("frz_inst", inst, memw(32'h4));
    end
    stall = 1'b0;
    step();
    chk("skid_new", got_new, 1);
    chk("req12", imem.req, 1);
    chk("addr12", imem.addr, 32'hC);

    // redirect while 0x10 is outstanding (latency 3)
    lat = 3;
    exp_pc.push_back(32'hC);
    exp_addr.push_back(32'h10);
    run_until_new(10);
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    lat      = 1;
    chk("drain_v", instValid, 0);
    chk("drain_inst", inst, FETCH_NOP);
    chk("drain_req", imem.req, 0);
    exp_addr.push_back(32'h100);
    exp_addr.push_back(32'h104);
    exp_pc.push_back(32'h100);
    run_until_new(10);

    // redirect + rvalid + stall together, unaligned target
    step();
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h203;
    exp_addr.push_back(32'h200);
    step();
    stall    = 1'b0;
    redirect = 1'b0;
    chk("rd_v", instValid, 0);
    chk("rd_inst", inst, FETCH_NOP);
    chk("rd_req", imem.req, 1);
    chk("rd_addr", imem.addr, 32'h200);
    exp_pc.push_back(32'h200);
    exp_addr.push_back(32'h204);
    run_until_new(8);

    // PC wrap at the top of the address space
    step();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    exp_addr.push_back(32'hFFFF_FFFC);
    exp_addr.push_back(32'h0);
    exp_pc.push_back(32'hFFFF_FFFC);
    exp_pc.push_back(32'h0);
    step();
    redirect = 1'b0;
    run_until_new(8);
    chk("wrap_pc4", pcAdd4, 32'h0);
    lat = 3;
    exp_addr.push_back(32'h4);
    run_until_new(8);

    // reset during WAIT; the late response lands in reset
    step();
    reset = 1'b0;
    repeat (3) step();
    chk_reset("rst2");
    reset = 1'b1;
    lat   = 1;
    exp_addr.push_back(32'h0);
    exp_addr.push_back(32'h4);
    exp_addr.push_back(32'h8);
    exp_pc.push_back(32'h0);
    exp_pc.push_back(32'h4);
    run_until_new(8);
    run_until_new(8);
    chk("pcq_left", exp_pc.size(), 0);
    chk("addrq_left", exp_addr.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule
